// File: rtl/led_band_reader_pkg.sv
// rtl/led_band_reader_pkg.sv - shared types and defaults for the LED band read scheduler
//
// Holds the scheduler state enum, the default band geometry and the output
// FIFO entry layout shared by led_band_reader and led_band_out_fifo.
package led_band_reader_pkg;

  localparam int unsigned DEF_COLUMNS          = 96;
  localparam int unsigned DEF_BYTES_PER_COLUMN = 144;
  localparam int unsigned ENTRY_DATA_WIDTH     = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  // One buffered byte plus its end-of-column tag.
  typedef struct packed {
    logic                        last;
    logic [ENTRY_DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/led_band_out_fifo.sv
// rtl/led_band_out_fifo.sv - 2-entry output FIFO between band memory and LED shifter
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i, entry_i   write one entry (ignored when full and not popping)
//   pop_i             remove the head entry (ignored when empty)
//   entry_o, valid_o  head entry and non-empty flag
//   count_o           current occupancy, 0..2
module led_band_out_fifo
  import led_band_reader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  fifo_entry_t entry_i,
  input  logic        pop_i,
  output fifo_entry_t entry_o,
  output logic        valid_o,
  output logic [1:0]  count_o
);

  fifo_entry_t mem_q [2];
  logic        wr_ptr_q;
  logic        rd_ptr_q;
  logic [1:0]  count_q;
  logic        do_push;
  logic        do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'd2) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign entry_o = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign count_o = count_q;

endmodule

// File: rtl/led_band_reader.sv
// rtl/led_band_reader.sv - per-column read scheduler streaming band memory bytes to the LED shifter
//
// On column_start it reads BYTES_PER_COLUMN consecutive bytes from the band
// memory (1-cycle read latency) and streams them out over valid/ready. A
// 2-entry FIFO absorbs the read latency; reads are throttled so buffered plus
// in-flight bytes never exceed 2.
//
// Build option: LED_BAND_DOUBLE_BUFFER_EN enables frame double-buffering via
// the top address bit; without it the bank bit and wr_bank are tied 0.
//
// Ports:
//   clk, nrst                  clock, asynchronous active-low reset
//   column_start, column_idx   start pulse and column to read
//   mem_read, mem_addr         read request to band memory
//   mem_data                   read data, valid the cycle after mem_read
//   out_data/valid/ready/last  byte stream to the LED shifter
//   busy                       column transfer in progress
//   overrun, start_err         dropped-start pulses (busy / index out of range)
//   swap_req, wr_bank          frame swap request and writer bank select
module led_band_reader
  import led_band_reader_pkg::*;
#(
  parameter int unsigned R_ADDR_WIDTH     = 15,
  parameter int unsigned R_DATA_WIDTH     = 8,
  parameter int unsigned COLUMNS          = DEF_COLUMNS,
  parameter int unsigned BYTES_PER_COLUMN = DEF_BYTES_PER_COLUMN,
  parameter int unsigned COL_WIDTH        = 7
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    column_start,
  input  logic [COL_WIDTH-1:0]    column_idx,
  output logic                    mem_read,
  output logic [R_ADDR_WIDTH-1:0] mem_addr,
  input  logic [R_DATA_WIDTH-1:0] mem_data,
  output logic [R_DATA_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun,
  output logic                    start_err,
  input  logic                    swap_req,
  output logic                    wr_bank
);

  localparam int unsigned OFF_W = R_ADDR_WIDTH - 1;
  localparam int unsigned CNT_W = $clog2(BYTES_PER_COLUMN);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_COLUMN - 1);

  state_e           state_q;
  logic [OFF_W-1:0] base_q;
  logic [OFF_W-1:0] base_d;
  logic [CNT_W-1:0] byte_cnt_q;
  logic             rd_pend_q;    // read issued last cycle, data on mem_data now
  logic             last_pend_q;  // that read was the final byte of the column
  logic             overrun_q;
  logic             start_err_q;
  logic             read_bank;

  logic             start_ok;
  logic             issue;
  logic             pop;
  logic             fifo_valid;
  logic [1:0]       fifo_count;
  fifo_entry_t      push_entry;
  fifo_entry_t      head_entry;

  assign start_ok = column_start && (32'(column_idx) < COLUMNS);
  assign base_d   = OFF_W'(32'(column_idx) * BYTES_PER_COLUMN);
  assign pop      = fifo_valid && out_ready;

  // Credit check: a byte leaving this cycle frees its slot for a new read,
  // which keeps full rate with only two slots of storage.
  assign issue = (state_q == FETCH) &&
                 ((3'(fifo_count) + 3'(rd_pend_q)) < (3'd2 + 3'(pop)));

  assign mem_read = issue;
  assign mem_addr = {read_bank, base_q + OFF_W'(byte_cnt_q)};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      byte_cnt_q  <= '0;
      rd_pend_q   <= 1'b0;
      last_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      overrun_q   <= column_start && (state_q != IDLE);
      start_err_q <= column_start && (state_q == IDLE) && !start_ok;
      rd_pend_q   <= issue;
      last_pend_q <= issue && (byte_cnt_q == LAST_BYTE);
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            base_q     <= base_d;
            byte_cnt_q <= '0;
            state_q    <= FETCH;
          end
        end
        FETCH: begin
          if (issue) begin
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_q <= '0;
              state_q    <= DRAIN;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          // Leave once the final byte is handed over this cycle.
          if (!rd_pend_q && (fifo_count == {1'b0, pop})) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef LED_BAND_DOUBLE_BUFFER_EN
  logic bank_q;
  logic swap_pend_q;

  // The bank only flips at the start of a revolution so a frame is never
  // split across banks; extra swap requests while pending collapse into one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bank_q      <= 1'b0;
      swap_pend_q <= 1'b0;
    end else if ((state_q == IDLE) && start_ok && (column_idx == '0) && swap_pend_q) begin
      bank_q      <= ~bank_q;
      swap_pend_q <= swap_req;
    end else if (swap_req) begin
      swap_pend_q <= 1'b1;
    end
  end

  assign read_bank = bank_q;
  assign wr_bank   = ~bank_q;
`else
  logic unused_swap_req;

  assign unused_swap_req = swap_req;
  assign read_bank       = 1'b0;
  assign wr_bank         = 1'b0;
`endif

  assign push_entry = fifo_entry_t'({last_pend_q, mem_data});

  led_band_out_fifo u_out_fifo (
    .clk_i   (clk),
    .rst_ni  (nrst),
    .push_i  (rd_pend_q),
    .entry_i (push_entry),
    .pop_i   (pop),
    .entry_o (head_entry),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  assign out_data  = head_entry.data;
  assign out_valid = fifo_valid;
  assign out_last  = fifo_valid && head_entry.last;
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign start_err = start_err_q;

endmodule
